// File: rtl/led_seq_pkg.sv
// led_seq_pkg
// Shared types and default sizing for the LED pattern sequencer.
//   state_t : sequencer FSM states
//   step_t  : one pattern-table entry at the default sizing
package led_seq_pkg;

   localparam int NUM_LEDS_DEF = 4;
   localparam int DEPTH_DEF    = 8;
   localparam int CNT_W_DEF    = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [NUM_LEDS_DEF-1:0] pattern;
      logic [CNT_W_DEF-1:0]    duration;
   } step_t;

endpackage

// File: rtl/led_step_timer.sv
// led_step_timer
// Per-step up-counter. Counts while enabled, flags expiry when the count
// reaches the step duration and clears itself on that same edge.
// Ports:
//   clk        : clock
//   arst_n     : async active-low reset
//   i_en       : count enable (sequencer running); low holds the count at 0
//   i_duration : step length minus one
//   o_expire   : high in the last cycle of the current step
module led_step_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_duration,
   output logic             o_expire
);

   logic [CNT_W-1:0] r_count;
   logic             w_expire;

   assign w_expire = i_en && (r_count == i_duration);
   assign o_expire = w_expire;

   // Clearing whenever disabled guarantees a fresh run starts at 0 even
   // if the previous run was aborted mid-step.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)
         r_count <= '0;
      else if (!i_en || w_expire)
         r_count <= '0;
      else
         r_count <= r_count + 1'b1;
   end

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer
// Plays a programmable table of LED patterns, each held for a programmable
// number of cycles, for a set number of passes or forever.
// Ports:
//   clk, arst_n             : clock, async active-low reset
//   cfg_valid/cfg_ready     : table-write handshake (ready only in IDLE)
//   cfg_addr/pattern/duration : table entry to write
//   num_steps, repeat_cnt   : last step index and pass count (0 = forever)
//   start, stop             : launch / abort pulses
//   leds, busy, done        : registered LED drive, running flag, completion pulse
//
// state | meaning
// IDLE  | LEDs off, table writable, waiting for start
// RUN   | stepping through the table
// DONE  | one-cycle completion pulse, LEDs off
module led_sequencer
   import led_seq_pkg::*;
#(
   parameter int NUM_LEDS = NUM_LEDS_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     arst_n,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [$clog2(DEPTH)-1:0] cfg_addr,
   input  logic [NUM_LEDS-1:0]      cfg_pattern,
   input  logic [CNT_W-1:0]         cfg_duration,
   input  logic [$clog2(DEPTH)-1:0] num_steps,
   input  logic [7:0]               repeat_cnt,
   input  logic                     start,
   input  logic                     stop,
   output logic [NUM_LEDS-1:0]      leds,
   output logic                     busy,
   output logic                     done
);

   localparam int ADDR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [NUM_LEDS-1:0] pattern;
      logic [CNT_W-1:0]    duration;
   } entry_t;

   entry_t              r_table [DEPTH];
   state_t              r_state;
   logic [ADDR_W-1:0]   r_step;
   logic [ADDR_W-1:0]   r_num;
   logic [7:0]          r_rep;
   logic [7:0]          r_pass;
   logic [NUM_LEDS-1:0] r_leds;
   logic                r_busy;
   logic                r_done;
   logic                r_ready;
   logic                w_cfg_we;
   logic                w_expire;
   logic [ADDR_W-1:0]   w_next_step;

   assign w_cfg_we    = cfg_valid && r_ready;
   assign w_next_step = r_step + 1'b1;

   assign cfg_ready = r_ready;
   assign leds      = r_leds;
   assign busy      = r_busy;
   assign done      = r_done;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < DEPTH; i++)
            r_table[i] <= '0;
      end else if (w_cfg_we) begin
         r_table[cfg_addr] <= '{pattern: cfg_pattern, duration: cfg_duration};
      end
   end

   led_step_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (clk),
      .arst_n     (arst_n),
      .i_en       (r_state == RUN),
      .i_duration (r_table[r_step].duration),
      .o_expire   (w_expire)
   );

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state <= IDLE;
         r_step  <= '0;
         r_num   <= '0;
         r_rep   <= '0;
         r_pass  <= '0;
         r_leds  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && !stop) begin
                  r_state <= RUN;
                  r_step  <= '0;
                  r_pass  <= '0;
                  r_num   <= num_steps;
                  r_rep   <= repeat_cnt;
                  r_leds  <= r_table[0].pattern;
                  r_busy  <= 1'b1;
                  r_ready <= 1'b0;
               end
            end
            RUN: begin
               // stop wins over a simultaneous final expiry: no done pulse
               if (stop) begin
                  r_state <= IDLE;
                  r_step  <= '0;
                  r_leds  <= '0;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
               end else if (w_expire) begin
                  if (r_step == r_num) begin
                     if (r_rep != 8'd0 && r_pass == r_rep - 8'd1) begin
                        r_state <= DONE;
                        r_step  <= '0;
                        r_leds  <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_step <= '0;
                        r_pass <= r_pass + 8'd1;
                        r_leds <= r_table[0].pattern;
                     end
                  end else begin
                     r_step <= w_next_step;
                     r_leds <= r_table[w_next_step].pattern;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
               r_leds  <= '0;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
